// File: rtl/map_table_if.sv
// Rename-stage map table bus: source lookup, destination allocation, CDB wakeup, retire and recovery.
// PR width follows PHYS_REG_IDX_SZ, which defaults to 6 when the build does not set it.
`ifndef PHYS_REG_IDX_SZ
`define PHYS_REG_IDX_SZ 6
`endif

interface map_table_if #(
  parameter int ARCH_REGS = 32,
  parameter int PR_W      = `PHYS_REG_IDX_SZ + 1
);
  localparam int AR_W = $clog2(ARCH_REGS);

  logic [AR_W-1:0] rs1_idx;
  logic [AR_W-1:0] rs2_idx;
  logic [PR_W-1:0] rs1_pr;
  logic [PR_W-1:0] rs2_pr;
  logic            rs1_ready;
  logic            rs2_ready;
  logic            rename_en;
  logic [AR_W-1:0] rd_idx;
  logic [PR_W-1:0] new_pr;
  logic            free_avail;
  logic            alloc_req;
  logic            rename_stall;
  logic [PR_W-1:0] told_pr;
  logic            cdb_valid;
  logic [PR_W-1:0] cdb_pr;
  logic            retire_en;
  logic [AR_W-1:0] retire_idx;
  logic [PR_W-1:0] retire_pr;
  logic            recover_en;

  modport master (
    output rs1_idx, rs2_idx, rename_en, rd_idx, new_pr, free_avail,
           cdb_valid, cdb_pr, retire_en, retire_idx, retire_pr, recover_en,
    input  rs1_pr, rs2_pr, rs1_ready, rs2_ready, alloc_req, rename_stall, told_pr
  );

  modport slave (
    input  rs1_idx, rs2_idx, rename_en, rd_idx, new_pr, free_avail,
           cdb_valid, cdb_pr, retire_en, retire_idx, retire_pr, recover_en,
    output rs1_pr, rs2_pr, rs1_ready, rs2_ready, alloc_req, rename_stall, told_pr
  );
endinterface

// File: rtl/map_table.sv
// Speculative register alias table with retirement copy; lookups and alloc_req are combinational, map updates land next edge.
// Stalls (rename_stall) when the destination needs a PR and the free list is empty. MAP_TABLE_CDB_BYPASS_EN adds same-cycle CDB wakeup.
`ifndef PHYS_REG_IDX_SZ
`define PHYS_REG_IDX_SZ 6
`endif

module map_table #(
  parameter int ARCH_REGS = 32,
  parameter int PR_W      = `PHYS_REG_IDX_SZ + 1
) (
  input logic         clk,
  input logic         reset,
  map_table_if.slave  bus
);
  localparam int AR_W = $clog2(ARCH_REGS);

  logic [PR_W-1:0] spec_map [ARCH_REGS];
  logic [PR_W-1:0] arch_map [ARCH_REGS];
  logic            ready    [ARCH_REGS];

  logic            needs_pr;
  logic            alloc_req;
  logic [PR_W-1:0] rs1_pr;
  logic [PR_W-1:0] rs2_pr;
  logic            rs1_rdy_q;
  logic            rs2_rdy_q;
  logic            bypass1;
  logic            bypass2;
  logic            retire_wr;

  assign needs_pr  = bus.rename_en && (bus.rd_idx != '0);
  assign alloc_req = needs_pr && bus.free_avail && !bus.recover_en;
  assign retire_wr = bus.retire_en && (bus.retire_idx != '0);

  // Index 0 is hardwired to PR 0 and always ready.
  always_comb begin
    rs1_pr    = '0;
    rs2_pr    = '0;
    rs1_rdy_q = 1'b1;
    rs2_rdy_q = 1'b1;
    if (bus.rs1_idx != '0) begin
      rs1_pr    = spec_map[bus.rs1_idx];
      rs1_rdy_q = ready[bus.rs1_idx];
    end
    if (bus.rs2_idx != '0) begin
      rs2_pr    = spec_map[bus.rs2_idx];
      rs2_rdy_q = ready[bus.rs2_idx];
    end
  end

`ifdef MAP_TABLE_CDB_BYPASS_EN
  assign bypass1 = bus.cdb_valid && !bus.recover_en && (bus.cdb_pr == rs1_pr);
  assign bypass2 = bus.cdb_valid && !bus.recover_en && (bus.cdb_pr == rs2_pr);
`else
  assign bypass1 = 1'b0;
  assign bypass2 = 1'b0;
`endif

  assign bus.rs1_pr       = rs1_pr;
  assign bus.rs2_pr       = rs2_pr;
  assign bus.rs1_ready    = rs1_rdy_q || bypass1;
  assign bus.rs2_ready    = rs2_rdy_q || bypass2;
  assign bus.told_pr      = (bus.rd_idx == '0) ? '0 : spec_map[bus.rd_idx];
  assign bus.alloc_req    = alloc_req;
  assign bus.rename_stall = needs_pr && !bus.free_avail;

  // Retirement copy keeps updating during recovery so the restore sees the retiring write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REGS; i++) arch_map[i] <= PR_W'(i);
    end else if (retire_wr) begin
      arch_map[bus.retire_idx] <= bus.retire_pr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        spec_map[i] <= PR_W'(i);
        ready[i]    <= 1'b1;
      end
    end else if (bus.recover_en) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        spec_map[i] <= (retire_wr && bus.retire_idx == AR_W'(i)) ? bus.retire_pr : arch_map[i];
        ready[i]    <= 1'b1;
      end
    end else begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        if (alloc_req && bus.rd_idx == AR_W'(i)) begin
          spec_map[i] <= bus.new_pr;
          ready[i]    <= 1'b0;
        end else if (bus.cdb_valid && spec_map[i] == bus.cdb_pr) begin
          ready[i]    <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_map_table.sv
// Directed table-driven bench for map_table: rename chains, CDB wakeup, stall, retire and recovery, mid-run reset.
`ifndef PHYS_REG_IDX_SZ
`define PHYS_REG_IDX_SZ 6
`endif

module tb_map_table;
  localparam int PR_W = `PHYS_REG_IDX_SZ + 1;
`ifdef MAP_TABLE_CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    string           name;
    logic [4:0]      rs1, rs2, rd, ret_idx;
    logic [PR_W-1:0] new_pr, cdb_pr, ret_pr;
    bit              ren, favail, cdbv, retv, rec;
    logic [PR_W-1:0] e1pr, e2pr, etold;
    bit              e1r, e2r, ealloc, estall;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_bad = 0;
  vec_t vq[$];

  map_table_if #(.ARCH_REGS(32), .PR_W(PR_W)) bus ();
  map_table #(.ARCH_REGS(32), .PR_W(PR_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  function automatic vec_t mk(string name, int rs1, int rs2, int rd, bit ren, int npr, bit fa,
                              bit cv, int cp, bit rv, int ri, int rp, bit rec,
                              int e1pr, bit e1r, int e2pr, bit e2r, int etold, bit ea, bit es);
    vec_t v;
    v.name = name; v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 5'(rd); v.ren = ren;
    v.new_pr = PR_W'(npr); v.favail = fa; v.cdbv = cv; v.cdb_pr = PR_W'(cp);
    v.retv = rv; v.ret_idx = 5'(ri); v.ret_pr = PR_W'(rp); v.rec = rec;
    v.e1pr = PR_W'(e1pr); v.e1r = e1r; v.e2pr = PR_W'(e2pr); v.e2r = e2r;
    v.etold = PR_W'(etold); v.ealloc = ea; v.estall = es;
    return v;
  endfunction

  task automatic drive(vec_t v);
    bus.rs1_idx = v.rs1; bus.rs2_idx = v.rs2; bus.rd_idx = v.rd; bus.rename_en = v.ren;
    bus.new_pr = v.new_pr; bus.free_avail = v.favail; bus.cdb_valid = v.cdbv; bus.cdb_pr = v.cdb_pr;
    bus.retire_en = v.retv; bus.retire_idx = v.ret_idx; bus.retire_pr = v.ret_pr; bus.recover_en = v.rec;
  endtask

  task automatic check(vec_t v);
    logic [3*PR_W+3:0] act, exp;
    act = {bus.rs1_pr, bus.rs1_ready, bus.rs2_pr, bus.rs2_ready, bus.told_pr, bus.alloc_req, bus.rename_stall};
    exp = {v.e1pr, v.e1r, v.e2pr, v.e2r, v.etold, v.ealloc, v.estall};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {rs1_pr,rdy,rs2_pr,rdy,told,alloc,stall}=%0d,%0b,%0d,%0b,%0d,%0b,%0b want %0d,%0b,%0d,%0b,%0d,%0b,%0b",
               v.name, bus.rs1_pr, bus.rs1_ready, bus.rs2_pr, bus.rs2_ready, bus.told_pr, bus.alloc_req,
               bus.rename_stall, v.e1pr, v.e1r, v.e2pr, v.e2r, v.etold, v.ealloc, v.estall);
    end
  endtask

  initial begin
    //                 name           rs1 rs2 rd ren npr fa cv cp rv ri rp rec | e1pr e1r e2pr e2r told al st
    vq.push_back(mk("reset_read",      5, 0, 7, 0,  0, 1, 0, 0, 0, 0, 0, 0,   5, 1,   0, 1,  7, 0, 0));
    vq.push_back(mk("ren3_40",         3, 2, 3, 1, 40, 1, 0, 0, 0, 0, 0, 0,   3, 1,   2, 1,  3, 1, 0));
    vq.push_back(mk("read3",           3, 0, 3, 0,  0, 1, 0, 0, 0, 0, 0, 0,  40, 0,   0, 1, 40, 0, 0));
    vq.push_back(mk("cdb40",           3, 0, 0, 0,  0, 1, 1,40, 0, 0, 0, 0,  40, BYP, 0, 1,  0, 0, 0));
    vq.push_back(mk("woke3",           3, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0,  40, 1,   0, 1,  0, 0, 0));
    vq.push_back(mk("ren3_41",         3, 3, 3, 1, 41, 1, 0, 0, 0, 0, 0, 0,  40, 1,  40, 1, 40, 1, 0));
    vq.push_back(mk("ren0",            0, 3, 0, 1, 42, 1, 0, 0, 0, 0, 0, 0,   0, 1,  41, 0,  0, 0, 0));
    vq.push_back(mk("stall4",          4, 0, 4, 1, 43, 0, 0, 0, 0, 0, 0, 0,   4, 1,   0, 1,  4, 0, 1));
    vq.push_back(mk("after_stall",     4, 3, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0,   4, 1,  41, 0,  0, 0, 0));
    vq.push_back(mk("ren_cdb_same",    3, 0, 3, 1, 44, 1, 1,41, 0, 0, 0, 0,  41, BYP, 0, 1, 41, 1, 0));
    vq.push_back(mk("cdb_dropped",     3, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0,  44, 0,   0, 1,  0, 0, 0));
    vq.push_back(mk("retire3_40",      3, 0, 0, 0,  0, 1, 0, 0, 1, 3,40, 0,  44, 0,   0, 1,  0, 0, 0));
    vq.push_back(mk("ren3_45",         3, 0, 3, 1, 45, 1, 0, 0, 0, 0, 0, 0,  44, 0,   0, 1, 44, 1, 0));
    vq.push_back(mk("recover",         3, 4, 0, 0,  0, 1, 0, 0, 0, 0, 0, 1,  45, 0,   4, 1,  0, 0, 0));
    vq.push_back(mk("restored",        3, 4, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0,  40, 1,   4, 1,  0, 0, 0));
    vq.push_back(mk("rec_ret_ren",     6, 0, 6, 1, 46, 1, 0, 0, 1, 6,50, 1,   6, 1,   0, 1,  6, 0, 0));
    vq.push_back(mk("restored6",       6, 3, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0,  50, 1,  40, 1,  0, 0, 0));

    reset = 1'b1;
    drive(vq[0]);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    foreach (vq[k]) begin
      drive(vq[k]);
      #1 check(vq[k]);
      @(negedge clk);
    end

    // Reset asserted mid-run: outputs hold until the edge, then revert to identity map.
    reset = 1'b1;
    drive(mk("pre_reset", 6, 3, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 50, 1, 40, 1, 40, 0, 0));
    #1 check(mk("pre_reset", 6, 3, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 50, 1, 40, 1, 40, 0, 0));
    @(negedge clk);
    reset = 1'b0;
    #1 check(mk("post_reset", 6, 3, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 6, 1, 3, 1, 3, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/map_table.md
# map_table

Speculative register alias table for the rename stage; sole consumer of the physical-register free list's head. For each renamed instruction it translates two source architectural registers to physical registers with ready bits. It allocates the free-list head PR for the destination and returns the displaced mapping (`told_pr`) for the ROB. A retirement copy of the map is held internally and restores the speculative map in one cycle on branch recovery.

## Interface
- `ARCH_REGS`, 32: number of architectural registers; index width `AR_W = $clog2(ARCH_REGS)`.
- `PR_W`, `` `PHYS_REG_IDX_SZ+1 ``: physical register number width, identical to free-list PR width.
- Reset: `reset`, synchronous, active-high; clock `clk`.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `rs1_idx`, `rs2_idx`  in  AR_W  source arch registers.
- `rs1_pr`, `rs2_pr`  out  PR_W  current speculative mapping of each source.
- `rs1_ready`, `rs2_ready`  out  1  mapped PR value available.
- `rename_en`  in  1  valid instruction in rename this cycle.
- `rd_idx`  in  AR_W  destination arch register.
- `new_pr`  in  PR_W  free-list head PR (`front_head_pr`).
- `free_avail`  in  1  free list non-empty (`!is_empty`).
- `alloc_req`  out  1  drives free-list `dequeue_en`.
- `rename_stall`  out  1  destination needs a PR but none available.
- `told_pr`  out  PR_W  mapping of `rd_idx` before this cycle's update.
- `cdb_valid`  in  1  completion broadcast valid.
- `cdb_pr`  in  PR_W  completing PR.
- `retire_en`  in  1  ROB head retires a writing instruction.
- `retire_idx`  in  AR_W  retiring arch destination.
- `retire_pr`  in  PR_W  retiring new PR.
- `recover_en`  in  1  squash; restore speculative map from retirement map.

## Operation
- State: `spec_map[ARCH_REGS]`, `ready[ARCH_REGS]`, `arch_map[ARCH_REGS]`.
- Reset: `spec_map[i] = i`, `arch_map[i] = i`, `ready[i] = 1`. Free list is preloaded by top level with PRs `ARCH_REGS..` upward.
- Register 0 is hardwired: reads of index 0 return PR 0, ready 1; never remapped.
- Reads are combinational from current state; `told_pr = spec_map[rd_idx]`.
- `needs_pr = rename_en && rd_idx != 0`; `alloc_req = needs_pr && free_avail && !recover_en`; `rename_stall = needs_pr && !free_avail`.
- On `alloc_req`: `spec_map[rd_idx] <= new_pr`, `ready[rd_idx] <= 0`.
- On `cdb_valid`: every entry i with `spec_map[i] == cdb_pr` sets `ready[i] <= 1`, except the entry being written by rename this cycle.
- On `retire_en` with `retire_idx != 0`: `arch_map[retire_idx] <= retire_pr`.
- On `recover_en`: `spec_map <= arch_map` with that cycle's retire update forwarded; all `ready <= 1`; rename and CDB updates are dropped. Outputs remain combinational.
- Priority: reset > recover > rename > CDB for each entry.
- Sources equal to `rd_idx` in the same instruction read the old mapping.

## Timing
- Source lookup and `told_pr`: 0-cycle combinational.
- `alloc_req`/`rename_stall`: combinational from inputs; the free list pops at the same edge.
- Map update is visible to reads one cycle after the rename edge. Back-to-back renames of the same `rd` chain correctly.
- CDB wakeup is visible next cycle (see Configuration).
- Recovery takes 1 cycle; the restored map is readable the cycle after `recover_en`.
- Reset mid-operation discards all state on the next edge; outputs take reset values one cycle after reset is sampled.

## Configuration
- `MAP_TABLE_CDB_BYPASS_EN` defined: `rsN_ready` also asserts combinationally when `cdb_valid && cdb_pr == rsN_pr`. This bypass is suppressed while `recover_en`.
- Undefined: ready reflects registered state only; wakeup is one cycle later.

## Test plan
- Reset, `rs1_idx=5`, `rs2_idx=0`, `rd_idx=7` -> `rs1_pr=5` ready 1, `rs2_pr=0` ready 1, `told_pr=7`, `alloc_req=0`.
- Rename `rd=3`, `new_pr=40`, `free_avail=1` -> `alloc_req=1`, `told_pr=3`. Next cycle `rs1_idx=3` -> `rs1_pr=40`, ready 0. Second rename `rd=3`, `new_pr=41` -> `told_pr=40`.
- With `rs1` mapped to 40 not ready, `cdb_valid=1`, `cdb_pr=40` -> ready 1 same cycle with macro, next cycle without.
- Rename `rd=0` -> `alloc_req=0`, map unchanged. Rename `rd=4` with `free_avail=0` -> `rename_stall=1`, `alloc_req=0`, `spec_map[4]` stays 4.
- Rename `rd=3`→40, retire (3, 40), rename `rd=3`→41, then `recover_en` -> `rs1_idx=3` gives 40 ready 1; `rs1_idx=4` gives 4.
- `recover_en` with concurrent `retire_en` (6, 50) and rename `rd=6` -> `alloc_req=0`; next cycle `spec_map[6]=50` ready 1.
